// File: rtl/keccak_pkg.sv
// Shared Keccak/SHA3 constants and types for the padding/absorb front end.
package keccak_pkg;
    localparam int N              = 64;
    localparam int STATE_W        = 1600;
    localparam int RATE_LANES_256 = 17;
    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        OUT  = 2'd1,
        PAD  = 2'd2
    } absorb_state_e;

    // A final word can never carry more than one lane of bytes.
    function automatic logic [3:0] clamp_bytes(input logic [3:0] b);
        return (b > 4'd8) ? 4'd8 : b;
    endfunction
endpackage

// File: rtl/sha3_pad_absorb_if.sv
// Message-word input and padded-block output handshakes of sha3_pad_absorb.
interface sha3_pad_absorb_if;
    import keccak_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       in_data;
    logic               in_last;
    logic [3:0]         in_bytes;
    logic               blk_valid;
    logic               blk_ready;
    logic [STATE_W-1:0] blk_data;
    logic               blk_last;

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_last
    );

    modport master (
        output in_valid, in_data, in_last, in_bytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_last
    );
endinterface

// File: rtl/sha3_pad_absorb_pad_lane.sv
// Builds one padded lane: the low nbytes of data, the domain byte right after
// them, and zeros above.
module pad_lane
    import keccak_pkg::*;
(
    input  logic [N-1:0] data_i,
    input  logic [3:0]   nbytes_i,
    input  logic [7:0]   domain_i,
    output logic [N-1:0] lane_o
);
    always_comb begin
        lane_o = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(nbytes_i)) begin
                lane_o[8*k +: 8] = data_i[8*k +: 8];
            end else if (k == int'(nbytes_i)) begin
                lane_o[8*k +: 8] = domain_i;
            end
        end
    end
endmodule

// File: rtl/sha3_pad_absorb.sv
// Collects 64-bit message words into rate-sized blocks and applies SHA3
// multi-rate padding (domain byte ... 0x80) before handing blocks downstream.
//
// state | meaning
// FILL  | accepting message words into lane cnt
// OUT   | block presented, waiting for blk_ready
// PAD   | building the padding-only block after an exactly-full final block
module sha3_pad_absorb
    import keccak_pkg::*;
#(
    parameter int         RATE_LANES = RATE_LANES_256,
    parameter logic [7:0] DOMAIN     = PAD_DOMAIN
) (
    input  logic            clk,
    input  logic            rst_n,
    sha3_pad_absorb_if.slave bus
);
    localparam int CW = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATE_LANES - 1);

    absorb_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pad_pending_q, pad_pending_d;
    logic          last_q, last_d;
    logic [N-1:0]  lane_q [RATE_LANES];
    logic [N-1:0]  lane_d [RATE_LANES];

    logic [3:0]         nbytes;
    logic [N-1:0]       pad_out;
    logic [STATE_W-1:0] blk_flat;

    assign nbytes = bus.in_last ? clamp_bytes(bus.in_bytes) : 4'd8;

    pad_lane u_pad_lane (
        .data_i   (bus.in_data),
        .nbytes_i (nbytes),
        .domain_i (DOMAIN),
        .lane_o   (pad_out)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pad_pending_d = pad_pending_q;
        last_d        = last_q;
        lane_d        = lane_q;
        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    lane_d[cnt_q] = pad_out;
                    if (!bus.in_last) begin
                        if (cnt_q == LAST_LANE) begin
                            state_d = OUT;
                            last_d  = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (nbytes != 4'd8) begin
                        // OR keeps DOMAIN when both pad bytes share byte 7.
                        lane_d[RATE_LANES-1][N-1 -: 8] = lane_d[RATE_LANES-1][N-1 -: 8] | PAD_FINAL;
                        state_d = OUT;
                        last_d  = 1'b1;
                    end else if (cnt_q != LAST_LANE) begin
                        lane_d[cnt_q + 1'b1] = {{(N-8){1'b0}}, DOMAIN};
                        lane_d[RATE_LANES-1][N-1 -: 8] = lane_d[RATE_LANES-1][N-1 -: 8] | PAD_FINAL;
                        state_d = OUT;
                        last_d  = 1'b1;
                    end else begin
                        state_d       = OUT;
                        last_d        = 1'b0;
                        pad_pending_d = 1'b1;
                    end
                end
            end
            OUT: begin
                if (bus.blk_ready) begin
                    for (int i = 0; i < RATE_LANES; i++) lane_d[i] = '0;
                    cnt_d         = '0;
                    last_d        = 1'b0;
                    pad_pending_d = 1'b0;
                    state_d       = pad_pending_q ? PAD : FILL;
                end
            end
            PAD: begin
                lane_d[0][7:0] = DOMAIN;
                lane_d[RATE_LANES-1][N-1 -: 8] = lane_d[RATE_LANES-1][N-1 -: 8] | PAD_FINAL;
                last_d  = 1'b1;
                state_d = OUT;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= FILL;
            cnt_q         <= '0;
            pad_pending_q <= 1'b0;
            last_q        <= 1'b0;
            for (int i = 0; i < RATE_LANES; i++) lane_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pad_pending_q <= pad_pending_d;
            last_q        <= last_d;
            lane_q        <= lane_d;
        end
    end

    // Capacity bits above the rate stay zero.
    always_comb begin
        blk_flat = '0;
        for (int i = 0; i < RATE_LANES; i++) blk_flat[N*i +: N] = lane_q[i];
    end

    assign bus.in_ready  = (state_q == FILL);
    assign bus.blk_valid = (state_q == OUT);
    assign bus.blk_data  = blk_flat;
    assign bus.blk_last  = last_q;
endmodule

// File: doc/sha3_pad_absorb.md
SHA3_PAD_ABSORB -- requirements
Module: sha3_pad_absorb

Interface
REQ-001 SHALL have parameter RATE_LANES, default 17, meaning the rate in 64-bit lanes (17 = SHA3-256, 1088 bits).
REQ-002 SHALL have parameter DOMAIN, default 8'h06, meaning the SHA3 domain/first-pad byte.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 in_valid  in  1  message word valid.
REQ-006 in_ready  out  1  block accepts a word.
REQ-007 in_data  in  N (64)  message lane; byte k at bits [8k+7:8k].
REQ-008 in_last  in  1  word is the final word of the message.
REQ-009 in_bytes  in  4  valid bytes in the final word, 0..8; ignored unless in_last.
REQ-010 blk_valid  out  1  padded block valid.
REQ-011 blk_ready  in  1  downstream (string-to-array / permutation) accepts the block.
REQ-012 blk_data  out  1600  lane i at [64i+63:64i] for i<RATE_LANES; capacity bits [1599:64*RATE_LANES] zero.
REQ-013 blk_last  out  1  block is the final block of the message.

Function
REQ-014 SHALL have FSM states FILL, OUT, PAD.
REQ-015 in_ready SHALL be 1 only in FILL; a word transfers on in_valid && in_ready.
REQ-016 FILL, non-last word: store in lane cnt, cnt+1; at cnt==RATE_LANES-1, go to OUT with blk_last=0.
REQ-017 FILL, last word with in_bytes=b<8: lane cnt = data bytes 0..b-1, byte b = DOMAIN, bytes above b zero; lane RATE_LANES-1 byte 7 ORed with 8'h80; go to OUT with blk_last=1.
REQ-018 Last word with b=8 and cnt<RATE_LANES-1: lane cnt = full data; lane cnt+1 byte 0 = DOMAIN; 8'h80 ORed into final lane byte 7; go to OUT with blk_last=1.
REQ-019 Last word with b=8 and cnt==RATE_LANES-1: emit the full block with blk_last=0, set a pad_pending flag; the handshake in OUT goes to PAD.
REQ-020 When DOMAIN and 8'h80 land on the same byte, that byte SHALL be DOMAIN|8'h80 (8'h86 at default).
REQ-021 PAD: load lane 0 byte 0 = DOMAIN and final-lane byte 7 = 8'h80, all other lanes zero; go to OUT next cycle with blk_last=1.
REQ-022 OUT: blk_valid=1; blk_data and blk_last held stable until blk_ready; on handshake, buffer cleared to zero, cnt=0, next state FILL (or PAD if pad_pending, which then clears).
REQ-023 Latency: blk_valid rises the cycle after the handshake of the block-completing word.
REQ-024 Unfilled lanes SHALL read zero (buffer cleared on every block handshake and on reset).
REQ-025 in_bytes>8 with in_last SHALL be treated as 8.

Reset
REQ-026 On rst_n==0 at a rising edge: state=FILL, cnt=0, pad_pending=0, buffer zero; outputs blk_valid=0, blk_last=0, blk_data=0, in_ready=1 from the next cycle.
REQ-027 Reset mid-message or mid-OUT SHALL abandon the message with no block emitted.

Structure
REQ-028 keccak_pkg SHALL gain RATE_LANES_256=17 and PAD_DOMAIN=8'h06; N reused for lane width.
REQ-029 One combinational sub-module pad_lane (data, byte count, DOMAIN -> padded lane) SHALL be used.

Verification
REQ-030 Empty message: one word in_last=1, in_bytes=0 -> one block, lane0=64'h06, lane16=64'h8000_0000_0000_0000, others 0, blk_last=1.
REQ-031 "abc": in_data=64'h636261, in_last=1, in_bytes=3 -> lane0=64'h0000_0000_0663_6261, lane16=64'h80<<56, blk_last=1.
REQ-032 135 bytes (16 full words + last in_bytes=7) -> one block, lane16 byte 7 = 8'h86, blk_last=1.
REQ-033 136 bytes (17 full words, last in_bytes=8) -> block 1 data only, blk_last=0; block 2 lane0=64'h06, lane16=64'h80<<56, blk_last=1.
REQ-034 blk_ready held low 5 cycles in OUT -> blk_data/blk_last stable, in_ready=0, no word consumed.
REQ-035 rst_n low after 5 words -> next message "abc" produces exactly the REQ-031 block.
